muldiv_seq: RTL

- Iterative RV32M multiply/divide unit with its own sequencer, sitting beside the Execute-stage ALU.
- The decoder raises start for M-extension ops (opcode 0110011, funct7 = 0000001). The hazard unit stalls Fetch, Decode and Execute while busy is high.
- Produces one 32-bit result per accepted operation, selected by funct3, and forwards it into the ALUResult path on done.

---
 rtl/muldiv_pkg.sv | 43 ++++
 rtl/muldiv_step.sv | 46 ++++
 rtl/muldiv_seq.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the iterative RV32M multiply/divide unit.
//   muldiv_op_e    - funct3 encoding of the M-extension ops
//   muldiv_state_e - sequencer states
//   XLEN           - default operand/result width
//   DIV_BY_ZERO_Q  - quotient returned for a zero divisor
//   INT_MIN        - most negative XLEN-bit value (signed-overflow dividend)
package muldiv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_RUN  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } muldiv_state_e;

    localparam logic [XLEN-1:0] DIV_BY_ZERO_Q = '1;
    localparam logic [XLEN-1:0] INT_MIN       = {1'b1, {(XLEN-1){1'b0}}};

    // rs1 is treated as signed for MULH, MULHSU, DIV and REM.
    function automatic logic op_a_signed(input muldiv_op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // rs2 is treated as signed for MULH, DIV and REM (MULHSU keeps it unsigned).
    function automatic logic op_b_signed(input muldiv_op_e op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the multiply/divide datapath.
//   div_mode - 0: shift-add multiply step, 1: restoring divide step
//   acc      - product high word (multiply) / partial remainder (divide)
//   shr      - product low word + remaining multiplier bits (multiply) /
//              dividend bits still to shift out + quotient bits (divide)
//   opnd     - multiplicand (multiply) / divisor (divide)
//   acc_nxt  - next accumulator
//   shr_nxt  - next shift register; in divide mode its LSB is left 0 and
//              the sequencer merges qbit into it
//   qbit     - quotient bit produced by this divide step (0 when multiplying)
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int XLEN = muldiv_pkg::XLEN
) (
    input  logic            div_mode,
    input  logic [XLEN-1:0] acc,
    input  logic [XLEN-1:0] shr,
    input  logic [XLEN-1:0] opnd,
    output logic [XLEN-1:0] acc_nxt,
    output logic [XLEN-1:0] shr_nxt,
    output logic            qbit
);

    logic [XLEN:0] sum;   // acc + multiplicand, carry kept
    logic [XLEN:0] rsh;   // remainder shifted left with next dividend bit
    logic [XLEN:0] diff;  // trial subtraction

    always_comb begin
        sum  = {1'b0, acc} + (shr[0] ? {1'b0, opnd} : '0);
        rsh  = {acc, shr[XLEN-1]};
        diff = rsh - {1'b0, opnd};
        if (div_mode) begin
            // Remainder stays below the divisor, so rsh < 2*divisor and the
            // borrow out of bit XLEN cleanly says "does not fit".
            qbit    = ~diff[XLEN];
            acc_nxt = qbit ? diff[XLEN-1:0] : rsh[XLEN-1:0];
            shr_nxt = {shr[XLEN-2:0], 1'b0};
        end else begin
            qbit    = 1'b0;
            acc_nxt = sum[XLEN:1];
            shr_nxt = {sum[0], shr[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide unit with its own sequencer.
//   clk, reset - clock, synchronous active-high reset
//   start      - accept a new op (only in IDLE or DONE)
//   funct3     - op select (muldiv_op_e)
//   a, b       - rs1 / rs2 operands
//   flush      - abort; next edge returns to IDLE, result untouched
//   busy       - high in PREP, RUN, FIX
//   done       - one-cycle pulse in DONE, result valid
//   result     - registered result, held until the next completion
// Optional feature: define MULDIV_EARLY_OUT_EN to end multiplies as soon as
// the remaining multiplier bits are zero (and to fast-path b == 0 to 0).
// XLEN overrides must match muldiv_pkg::XLEN (package constants are sized by it).
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN = muldiv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    muldiv_state_e   state, state_nxt;
    muldiv_op_e      op;
    logic [XLEN-1:0] a_r, b_r;
    logic [XLEN-1:0] acc, shr, opnd;
    logic            neg_res;   // product / quotient sign
    logic            neg_rem;   // remainder sign follows the dividend
    logic [CW-1:0]   cnt;

    // Operand conditioning, evaluated while in PREP
    logic            div_op, a_sgn, b_sgn;
    logic [XLEN-1:0] a_abs, b_abs;
    logic            special;
    logic [XLEN-1:0] special_res;

    // Iteration and final fix-up
    logic [XLEN-1:0] acc_nxt, shr_nxt;
    logic            qbit;
    logic            last_iter;
    logic [XLEN-1:0] acc_run, shr_run;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0] fix_res;

    always_comb begin
        div_op      = op[2];
        a_sgn       = op_a_signed(op) && a_r[XLEN-1];
        b_sgn       = op_b_signed(op) && b_r[XLEN-1];
        a_abs       = a_sgn ? -a_r : a_r;
        b_abs       = b_sgn ? -b_r : b_r;
        special     = 1'b0;
        special_res = '0;
        if (div_op && (b_r == '0)) begin
            special     = 1'b1;
            // REM/REMU (op[1]=1) return the dividend, DIV/DIVU all ones
            special_res = op[1] ? a_r : DIV_BY_ZERO_Q;
        end else if (((op == OP_DIV) || (op == OP_REM)) && (a_r == INT_MIN) && (b_r == '1)) begin
            special     = 1'b1;
            special_res = op[1] ? '0 : INT_MIN;
        end
`ifdef MULDIV_EARLY_OUT_EN
        else if (!div_op && (b_abs == '0)) begin
            special     = 1'b1;
            special_res = '0;
        end
`endif
    end

    muldiv_step #(.XLEN(XLEN)) u_step (
        .div_mode (div_op),
        .acc      (acc),
        .shr      (shr),
        .opnd     (opnd),
        .acc_nxt  (acc_nxt),
        .shr_nxt  (shr_nxt),
        .qbit     (qbit)
    );

`ifdef MULDIV_EARLY_OUT_EN
    // After this step, cnt iterations remain and the low cnt bits of the
    // shift register are the multiplier bits not yet consumed. When those
    // are all zero the remaining steps are pure shifts, done in one go.
    logic [XLEN-1:0] rem_mask;
    logic            early;
    always_comb begin
        rem_mask           = (XLEN'(1) << cnt) - XLEN'(1);
        early              = !div_op && (((shr_nxt | XLEN'(qbit)) & rem_mask) == '0);
        last_iter          = (cnt == '0) || early;
        {acc_run, shr_run} = early ? ({acc_nxt, shr_nxt} >> cnt) : {acc_nxt, shr_nxt | XLEN'(qbit)};
    end
`else
    always_comb begin
        last_iter = (cnt == '0);
        acc_run   = acc_nxt;
        shr_run   = shr_nxt | XLEN'(qbit);
    end
`endif

    always_comb begin
        prod   = {acc, shr};
        prod_s = neg_res ? -prod : prod;
        case (op)
            OP_MUL:                      fix_res = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:             fix_res = neg_res ? -shr : shr;
            default:                     fix_res = neg_rem ? -acc : acc;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; flush overrides everything, including a same-cycle start
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_PREP;
            S_PREP:  state_nxt = special ? S_DONE : S_RUN;
            S_RUN:   if (last_iter) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_DONE;
            S_DONE:  state_nxt = start ? S_PREP : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (flush) state_nxt = S_IDLE;
    end

    // Outputs
    always_comb begin
        busy = (state == S_PREP) || (state == S_RUN) || (state == S_FIX);
        done = (state == S_DONE);
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            op      <= OP_MUL;
            a_r     <= '0;
            b_r     <= '0;
            acc     <= '0;
            shr     <= '0;
            opnd    <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            cnt     <= '0;
            result  <= '0;
        end else if (!flush) begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        op  <= muldiv_op_e'(funct3);
                        a_r <= a;
                        b_r <= b;
                    end
                end
                S_PREP: begin
                    acc     <= '0;
                    cnt     <= CW'(XLEN-1);
                    neg_res <= a_sgn ^ b_sgn;
                    neg_rem <= a_sgn;
                    // Multiply shifts the multiplier through shr; divide
                    // shifts the dividend through it.
                    shr     <= div_op ? a_abs : b_abs;
                    opnd    <= div_op ? b_abs : a_abs;
                    if (special) result <= special_res;
                end
                S_RUN: begin
                    acc <= acc_run;
                    shr <= shr_run;
                    cnt <= cnt - CW'(1);
                end
                S_FIX: result <= fix_res;
                default: ;
            endcase
        end
    end

endmodule
